// File: rtl/mips16_prog_loader.sv
// mips16_prog_loader
// Boot-time loader for the 16-bit MIPS core. It takes a byte stream over a
// valid/ready handshake, builds 16-bit instruction words, writes them into
// instruction memory, checks an XOR checksum and keeps the core in reset
// until a load finishes cleanly.
//
// The stream is: count high byte, count low byte, N words (high byte then
// low byte), then a checksum byte equal to the XOR of every byte before it.
//
// Ports:
//   clk        : single clock, all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   start      : one-cycle pulse; begins a load from IDLE, RUN or ERR
//   rx_data    : stream byte
//   rx_valid   : rx_data is valid
//   rx_ready   : a byte can be accepted this cycle
//   imem_we    : instruction-memory write strobe (one cycle per word)
//   imem_addr  : instruction-memory word address
//   imem_wdata : instruction word
//   cpu_reset  : active-high reset to the core
//   busy       : load in progress
//   done       : load finished with a good checksum, core running
//   err        : bad word count or bad checksum
//
// state  | meaning
// IDLE   | after reset, waiting for start
// CNT_HI | waiting for word-count high byte
// CNT_LO | waiting for word-count low byte, range-check the count
// DAT_HI | waiting for high byte of the next word
// DAT_LO | waiting for low byte of the next word
// WRITE  | one-cycle instruction-memory write
// CHK    | waiting for checksum byte
// HOLD   | good checksum, counting down before releasing the core
// RUN    | core released
// ERR    | load failed, core held in reset

module mips16_prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          HW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO,
    S_WRITE, S_CHK, S_HOLD, S_RUN, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic              accept;
  logic [15:0]       cnt_full;
  logic              last_word;

  assign accept    = rx_valid && rx_ready;
  assign cnt_full  = {cnt_q[15:8], rx_data};
  // Index is one bit wider than the address so N = 2^ADDR_W fits.
  assign last_word = (17'(idx_q) == (17'(cnt_q) - 17'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_CNT_HI;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_d[15:8] = rx_data;
          acc_d       = acc_q ^ rx_data;
          state_d     = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_d = cnt_full;
          acc_d = acc_q ^ rx_data;
          if (cnt_full == 16'd0 || 17'(cnt_full) > MAX_N) state_d = S_ERR;
          else                                             state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = last_word ? S_CHK : S_DAT_HI;
      end
      S_CHK: begin
        if (accept) begin
          if (rx_data == acc_q) begin
            state_d = S_HOLD;
            hold_d  = HW'(HOLD_CYCLES);
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (hold_q <= HW'(1)) state_d = S_RUN;
        else                  hold_d  = hold_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come only from registers so nothing depends combinationally
  // on the stream inputs.
  assign rx_ready   = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                      (state_q == S_DAT_HI) || (state_q == S_DAT_LO) ||
                      (state_q == S_CHK);
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = idx_q[ADDR_W-1:0];
  assign imem_wdata = {hi_q, lo_q};
  assign cpu_reset  = (state_q != S_RUN);
  assign busy       = (state_q != S_IDLE) && (state_q != S_RUN) &&
                      (state_q != S_ERR);
  assign done       = (state_q == S_RUN);
  assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_mips16_prog_loader.sv
module tb_mips16_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  mips16_prog_loader #(.ADDR_W(8), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // write log, filled by a monitor sampling on the falling edge
  int          wr_cnt  = 0;
  int          err_cyc = 0;
  logic [7:0]  log_addr [0:1023];
  logic [15:0] log_data [0:1023];

  always @(negedge clk) begin
    if (imem_we && wr_cnt < 1024) begin
      log_addr[wr_cnt] = imem_addr;
      log_data[wr_cnt] = imem_wdata;
      wr_cnt = wr_cnt + 1;
    end
    if (err) err_cyc = err_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns just after the accepting rising edge (+1).
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: got no rx_ready expected rx_ready within 20 cycles");
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Counts rising edges until done or err appears.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!(done || err) && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (cyc >= 40) begin
      checks++;
      errors++;
      $display("FAIL wait_result_timeout: got no done/err expected one within 40 cycles");
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] bytes;
    int          len;
    bit          gaps;
    bit          exp_err;
    int          exp_lat;
    int          exp_nw;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  function automatic vec_t mk(string n, logic [63:0] b, int l, bit g, bit e,
                              int lat, int nw, logic [15:0] a, logic [15:0] c);
    vec_t v;
    v.name = n; v.bytes = b; v.len = l; v.gaps = g; v.exp_err = e;
    v.exp_lat = lat; v.exp_nw = nw; v.w0 = a; v.w1 = c;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    int base, cyc, ecyc;
    logic [7:0] x;

    vecs[0] = mk("good",      64'h0002_1234_ABCD_4200, 7, 0, 0, 4, 2, 16'h1234, 16'hABCD);
    vecs[1] = mk("bad_chk",   64'h0002_1234_ABCD_4300, 7, 0, 1, 0, 2, 16'h1234, 16'hABCD);
    vecs[2] = mk("n_zero",    64'h0000_0000_0000_0000, 2, 0, 1, 0, 0, 16'h0,    16'h0);
    vecs[3] = mk("n_257",     64'h0101_0000_0000_0000, 2, 0, 1, 0, 0, 16'h0,    16'h0);
    vecs[4] = mk("good_gaps", 64'h0002_1234_ABCD_4200, 7, 1, 0, 4, 2, 16'h1234, 16'hABCD);
    vecs[5] = mk("one_word",  64'h0001_FF00_FE00_0000, 5, 0, 0, 4, 1, 16'hFF00, 16'h0);

    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_rx_ready",  32'(rx_ready), 0);
    chk("rst_imem_we",   32'(imem_we), 0);
    chk("rst_addr",      32'(imem_addr), 0);
    chk("rst_wdata",     32'(imem_wdata), 0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cpu_reset", 32'(cpu_reset), 1);

    for (int i = 0; i < 6; i++) begin
      base = wr_cnt;
      pulse_start();
      chk({vecs[i].name, "_busy"}, 32'(busy), 1);
      ecyc = err_cyc;
      for (int k = 0; k < vecs[i].len; k++)
        send_byte(vecs[i].bytes[63-8*k -: 8], vecs[i].gaps);
      wait_result(cyc);
      chk({vecs[i].name, "_latency"}, 32'(cyc), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_done"}, 32'(done), 32'(!vecs[i].exp_err));
      chk({vecs[i].name, "_cpu_reset"}, 32'(cpu_reset), 32'(vecs[i].exp_err));
      @(negedge clk);
      chk({vecs[i].name, "_nwrites"}, 32'(wr_cnt - base), 32'(vecs[i].exp_nw));
      if (!vecs[i].exp_err)
        chk({vecs[i].name, "_err_during_load"}, 32'(err_cyc - ecyc), 0);
      if (vecs[i].exp_nw >= 1) begin
        chk({vecs[i].name, "_w0_addr"}, 32'(log_addr[base]), 0);
        chk({vecs[i].name, "_w0_data"}, 32'(log_data[base]), 32'(vecs[i].w0));
      end
      if (vecs[i].exp_nw >= 2) begin
        chk({vecs[i].name, "_w1_addr"}, 32'(log_addr[base+1]), 1);
        chk({vecs[i].name, "_w1_data"}, 32'(log_data[base+1]), 32'(vecs[i].w1));
      end
    end

    // full-capacity load: 256 words, last one lands at 0xFF
    base = wr_cnt;
    pulse_start();
    x = 8'h01 ^ 8'h00;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 256; k++) begin
      send_byte(8'(k), 0);
      send_byte(~8'(k), 0);
      x = x ^ 8'(k) ^ ~8'(k);
    end
    send_byte(x, 0);
    wait_result(cyc);
    chk("n256_done", 32'(done), 1);
    chk("n256_latency", 32'(cyc), 4);
    chk("n256_nwrites", 32'(wr_cnt - base), 256);
    chk("n256_last_addr", 32'(log_addr[base+255]), 32'hFF);
    chk("n256_last_data", 32'(log_data[base+255]), 32'hFF00);

    // start mid-load is ignored
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("midstart_busy", 32'(busy), 1);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(8'h42, 0);
    wait_result(cyc);
    chk("midstart_done", 32'(done), 1);
    chk("midstart_nwrites", 32'(wr_cnt - base), 2);

    // start from RUN: core back in reset on the next edge, words overwritten
    base = wr_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("restart_cpu_reset", 32'(cpu_reset), 1);
    chk("restart_done", 32'(done), 0);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    send_byte(8'h77, 0); send_byte(8'h88, 0);
    send_byte(8'hCE, 0);
    wait_result(cyc);
    chk("restart_done_final", 32'(done), 1);
    @(negedge clk);
    chk("restart_w0", {log_addr[base], 8'h00, log_data[base]}, 32'h0000_5566);
    chk("restart_w1", {log_addr[base+1], 8'h00, log_data[base+1]}, 32'h0100_7788);

    // reset asserted while in DAT_LO
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    chk("dlo_rx_ready", 32'(rx_ready), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_cpu_reset", 32'(cpu_reset), 1);
    chk("arst_rx_ready", 32'(rx_ready), 0);
    chk("arst_we_addr_wdata", {7'd0, imem_we, imem_addr, imem_wdata}, 0);
    chk("arst_busy_done_err", {29'd0, busy, done, err}, 0);
    rx_data = 8'hCD; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    chk("arst_nwrites", 32'(wr_cnt - base), 1);
    chk("arst_idle", {28'd0, cpu_reset, busy, done, err}, 32'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips16_prog_loader.md
# mips16_prog_loader

Boot-time program loader placed in front of the 16-bit single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into instruction memory. It verifies an XOR checksum and holds the core's active-high `reset` asserted until a load completes cleanly. It is the upstream stage that prepares the core before it runs.

## Interface
- `ADDR_W`, 8, instruction-memory address width; capacity is 2^ADDR_W words.
- `HOLD_CYCLES`, 4, cycles `cpu_reset` stays high after a good checksum; must be ≥1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, RUN, ERR.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  16  word to write.
- `cpu_reset`  out  1  active-high reset to the core.
- `busy`  out  1  load in progress (states CNT_HI through HOLD).
- `done`  out  1  high in RUN.
- `err`  out  1  high in ERR.

## Operation
- Stream format after `start`:
  - CNT_HI, then CNT_LO: 16-bit word count N, big-endian.
  - N words, each as a HI byte then a LO byte.
  - One CHK byte, equal to the XOR of every preceding byte in the stream, including the count bytes.
- A byte is accepted on a rising edge when `rx_valid & rx_ready`.
- `rx_ready` is 1 only in CNT_HI, CNT_LO, DAT_HI, DAT_LO and CHK.
- States and transitions:
  - IDLE: on `start`, go to CNT_HI and clear the checksum accumulator and word index.
  - CNT_HI → CNT_LO on accept.
  - CNT_LO on accept:
    - if N == 0 or N > 2^ADDR_W, go to ERR;
    - otherwise go to DAT_HI.
  - DAT_HI → DAT_LO on accept; latch the high byte.
  - DAT_LO → WRITE on accept.
  - WRITE (one cycle):
    - `imem_we=1`, `imem_addr` = index, `imem_wdata` = {hi, lo};
    - increment the index;
    - go to CHK if the index was N−1, else to DAT_HI.
  - CHK on accept:
    - byte equals the accumulator: go to HOLD and load the hold counter with HOLD_CYCLES;
    - otherwise go to ERR.
  - HOLD: decrement the counter each cycle; go to RUN when it reaches 1.
  - RUN: `cpu_reset=0`, `done=1`; on `start`, go to CNT_HI.
  - ERR: `err=1`, `cpu_reset=1`; on `start`, go to CNT_HI.
- `start` in any busy state is ignored.
- The accumulator XORs every accepted byte except the CHK byte.
- The word index is ADDR_W+1 bits wide, so N = 2^ADDR_W is legal and the final address is 2^ADDR_W−1.
- `imem_addr` uses the low ADDR_W bits of the index.
- Words already written before an ERR stay in memory; there is no rollback.

## Timing
- Reset values (asynchronous, `reset=0`):
  - state = IDLE;
  - `cpu_reset=1`;
  - `rx_ready=0`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`;
  - `busy=0`, `done=0`, `err=0`.
- Reset mid-load aborts immediately. No further writes occur, and `cpu_reset` stays 1.
- All outputs are registered or decoded from the state register only; none combinationally depends on inputs.
- Minimum 3 cycles per word (DAT_HI, DAT_LO, WRITE) with `rx_valid` held high.
- `imem_we` is high exactly in the cycle after the LO byte is accepted.
- `cpu_reset` falls HOLD_CYCLES cycles after the edge that accepts a correct CHK byte. `done` rises on the same edge.
- `start` from RUN: `cpu_reset` rises and `done` falls on the next edge.
- Gaps in `rx_valid` stall the FSM in its current state without side effects.

## Test plan
- Good load, ADDR_W=8, HOLD_CYCLES=4, bytes 00 02 12 34 AB CD 42 (CHK=0x42), `rx_valid` held high:
  - writes addr0=0x1234, then addr1=0xABCD;
  - `cpu_reset` falls and `done` rises 4 cycles after CHK is accepted;
  - `err=0` throughout.
- Bad checksum, same stream with final byte 43:
  - both writes still occur;
  - `err=1` one cycle after CHK is accepted;
  - `cpu_reset` stays 1 and `done=0`.
- Count bounds:
  - N=0000 → ERR after CNT_LO, no writes;
  - N=0101 (257) → ERR, no writes;
  - N=0100 (256) with a correct CHK → last write at addr 0xFF, then RUN.
- Backpressure: same good stream with `rx_valid` low on random cycles → identical writes and result; `imem_we` never asserted twice for one word.
- `start` pulsed mid-load is ignored. `start` in RUN restarts the load: `cpu_reset=1` on the next edge, and a new stream overwrites the words.
- `reset` dropped low while in DAT_LO:
  - outputs return to reset values immediately;
  - after release the loader sits in IDLE with `cpu_reset=1` until a new `start`.
